rcb_frl_counter_nx: RTL

Parametrised event counter for the Fast Radio Link (FRL) receive/transmit control paths. It generalises the fixed 4-bit up-counter to:
- configurable width and terminal value;
- up/down direction, synchronous clear and parallel load;
- wrap, saturate and one-shot modes;
- an event prescaler, plus wrap/overflow/done status.

FRL training, bit-slip and frame-alignment logic instantiate it wherever a bounded count of qualifying events is needed.

---
 rtl/rcb_frl_counter_nx.sv | 100 ++++++++++
 1 files changed

// File: rtl/rcb_frl_counter_nx.sv
// Bounded event counter: up/down, wrap/saturate/one-shot, prescaled steps, sticky status.
// Latency: every output is a flop updated one edge after its inputs; no backpressure, inputs sampled every cycle.
module rcb_frl_counter_nx #(
  parameter int WIDTH     = 4,
  parameter int MAX_VALUE = 15,
  parameter int MODE      = 0,
  parameter int PRESCALE  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             count,
  input  logic             down,
  output logic [WIDTH-1:0] counter_value,
  output logic             wrap_pulse,
  output logic             overflow,
  output logic             done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] ZERO_W   = '0;
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             step;
  logic [WIDTH-1:0] bound;

  always_comb begin
    cnt_d  = cnt_q;
    pre_d  = pre_q;
    wrap_d = 1'b0;
    ovf_d  = ovf_q;
    done_d = done_q;
    step   = 1'b0;
    bound  = down ? ZERO_W : MAX_W;

    if (clear) begin
      cnt_d  = '0;
      pre_d  = '0;
      ovf_d  = 1'b0;
      done_d = 1'b0;
    end else if (load) begin
      cnt_d  = (load_value > MAX_W) ? MAX_W : load_value;
      pre_d  = '0;
      done_d = 1'b0;
    end else if (count && !(MODE == 2 && done_q)) begin
      // A finished one-shot freezes the prescaler as well as the count.
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        step  = 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end

    if (step) begin
      if (cnt_q != bound) begin
        cnt_d = down ? (cnt_q - 1'b1) : (cnt_q + 1'b1);
      end else if (MODE == 0) begin
        cnt_d  = down ? MAX_W : ZERO_W;
        wrap_d = 1'b1;
        ovf_d  = 1'b1;
      end else if (MODE == 1) begin
        ovf_d = 1'b1;
      end
      if (MODE == 2 && cnt_d == bound) begin
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      pre_q  <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pre_q  <= pre_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
      done_q <= done_d;
    end
  end

  assign counter_value = cnt_q;
  assign wrap_pulse    = wrap_q;
  assign overflow      = ovf_q;
  assign done          = done_q;

endmodule
